mult_accum_stage: RTL
=====================

Name: mult_accum_stage

Overview:
- Sequential stage directly downstream of the combinational 8x8 array multiplier.
- Accepts a stream of 16-bit unsigned products under a valid/ready handshake and accumulates a programmed number of them into a saturating accumulator.
- Presents the final sum with an output valid/ready handshake.
- Turns the multiplier into a dot-product / multiply-accumulate datapath.

Parameters:
- PROD_W, 16, width of incoming product (matches multiplier output p).
- ACC_W, 24, accumulator and result width; must be > PROD_W.
- CNT_W, 8, width of the transaction length field (max 2^CNT_W-1 products).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a new accumulation; honoured only in IDLE.
- len  input  CNT_W  number of products to accumulate; sampled with start.
- prod  input  PROD_W  unsigned product from the multiplier.
- prod_valid  input  1  prod is valid this cycle.
- prod_ready  output  1  stage accepts prod this cycle.
- acc_out  output  ACC_W  accumulated result.
- out_valid  output  1  acc_out holds a completed result.
- out_ready  input  1  consumer accepts result.
- busy  output  1  high in ACCUM or DONE.
- overflow  output  1  sticky flag: saturation occurred in current/last transaction.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset (async assert, any state, including mid-transaction):
  - state=IDLE; acc_out=0, count=0.
  - prod_ready=0, out_valid=0, busy=0, overflow=0.
  - Any partial sum is discarded.
- FSM states: IDLE, ACCUM, DONE. All outputs are registered or decoded from state only; no combinational path from inputs to outputs.
- IDLE:
  - prod_ready=0, out_valid=0.
  - start=1 and len!=0: acc<=0, overflow<=0, count<=len, go to ACCUM.
  - start=1 and len==0: acc<=0, overflow<=0, go directly to DONE (result 0 one cycle after start).
- ACCUM:
  - prod_ready=1, busy=1.
  - A transfer happens on a cycle where prod_valid & prod_ready.
  - On each transfer: acc<=sat(acc+zero-extended prod), count<=count-1.
  - Sum is computed at ACC_W+1 bits. On carry out: acc<=all ones, overflow<=1. Once saturated, acc stays all ones for the rest of the transaction.
  - Transfer with count==1: go to DONE.
  - prod_valid=0 cycles (gaps) leave acc and count unchanged.
  - start is ignored.
- DONE:
  - out_valid=1, prod_ready=0, busy=1.
  - acc_out and overflow are held stable while out_valid=1 and out_ready=0.
  - out_ready=1: go to IDLE next edge. acc_out and overflow keep their value until the next accepted start.
  - start is ignored in DONE, even when it coincides with out_ready.
- Latency: out_valid rises on the clock edge that accepts the last product, so it is visible the cycle after that transfer. Throughput is one product per cycle. At least one IDLE cycle separates consecutive transactions.
- acc_out in ACCUM shows the running partial sum. It is meaningful only when out_valid=1.

Test Plan:
- len=3, prod=65025 on 3 consecutive cycles, out_ready=1 -> prod_ready high 3 cycles; next cycle out_valid=1, acc_out=195075 (0x02FA03), overflow=0; IDLE the following cycle.
- len=4, prods 10,20,30,40 with prod_valid low for 2 cycles between each, out_ready=0 for 5 cycles after DONE -> acc_out=100 held stable with out_valid=1 for 5 cycles; IDLE one cycle after out_ready=1.
- ACC_W=17, len=3, prod=65025 x3 -> acc_out=131071 (all ones), overflow=1; overflow clears to 0 on next start.
- start with len=0 -> cycle after start: out_valid=1, acc_out=0; start pulsed during ACCUM and DONE has no effect on count or result.
- len=5, rst asserted asynchronously mid-cycle after 2 products -> outputs immediately 0/IDLE; new start len=1, prod=7 -> acc_out=7.
- Back-to-back: two transactions (len=2: 1,2 then len=2: 3,4), next start issued the first IDLE cycle -> results 3 then 7, no carry-over of acc between transactions.

Source files
------------

// File: rtl/mult_accum_stage.sv
// ----------------------------------------------------------------------------
// mult_accum_stage
//
// Sequential stage that sits after the combinational 8x8 array multiplier.
// It takes a programmed number of unsigned products over a valid/ready
// handshake and adds them into a saturating accumulator. The finished sum is
// then offered on a second valid/ready handshake. Together with the
// multiplier this forms a dot-product / multiply-accumulate datapath.
//
// Ports:
//   clk         clock, rising edge
//   rst         asynchronous active-high reset
//   start       one-cycle request to begin an accumulation (IDLE only)
//   len         number of products to accumulate, sampled with start
//   prod        unsigned product from the multiplier
//   prod_valid  prod is valid this cycle
//   prod_ready  stage accepts prod this cycle (high in ACCUM)
//   acc_out     accumulated result (running partial sum while in ACCUM)
//   out_valid   acc_out holds a completed result (high in DONE)
//   out_ready   consumer accepts the result
//   busy        high in ACCUM or DONE
//   overflow    sticky saturation flag for the current/last transaction
//
// State | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for start; the last result and overflow are held
// ACCUM | accepting products until the programmed count is exhausted
// DONE  | result presented on out_valid until out_ready
// ----------------------------------------------------------------------------
module mult_accum_stage #(
  parameter int PROD_W = 16,
  parameter int ACC_W  = 24,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  len,
  input  logic [PROD_W-1:0] prod,
  input  logic              prod_valid,
  output logic              prod_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              overflow
);

  if (ACC_W <= PROD_W) begin : g_bad_width
    $error("mult_accum_stage: ACC_W must be greater than PROD_W");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               overflow_q, overflow_d;

  logic               xfer;
  logic [ACC_W:0]     sum;

  // prod_ready is decoded from state, so a transfer is simply valid in ACCUM.
  assign xfer = (state_q == S_ACCUM) && prod_valid;

  // One extra bit catches the carry out that triggers saturation. Once the
  // accumulator is all ones any nonzero product carries again, so saturation
  // is naturally sticky for the rest of the transaction.
  assign sum = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod};

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d      = '0;
          overflow_d = 1'b0;
          count_d    = len;
          if (len == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ACCUM;
          end
        end
      end

      S_ACCUM: begin
        if (xfer) begin
          count_d = count_q - 1'b1;
          if (sum[ACC_W]) begin
            acc_d      = '1;
            overflow_d = 1'b1;
          end else begin
            acc_d = sum[ACC_W-1:0];
          end
          if (count_q == {{(CNT_W-1){1'b0}}, 1'b1}) begin
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      acc_q      <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign prod_ready = (state_q == S_ACCUM);
  assign out_valid  = (state_q == S_DONE);
  assign busy       = (state_q == S_ACCUM) || (state_q == S_DONE);
  assign acc_out    = acc_q;
  assign overflow   = overflow_q;

endmodule
